// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator side of the ALU operand/control interface.
// Accepts a request and decodes the opcode into the ALU control code.
// Drives registered operands, waits a settle time, then captures the result and flags.
// Returns result/flags/error over a valid/ready response handshake.
module alu_sequencer #(
  parameter int N         = 32,
  parameter int SETTLE    = 1,
  parameter int SETTLE_MD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_n,
  output logic         rsp_z,
  output logic         rsp_c,
  output logic         rsp_v,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [5:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v
);

  localparam int MAX_SETTLE = (SETTLE > SETTLE_MD) ? SETTLE : SETTLE_MD;
  // The counter only ever holds settle-1, so clog2(max) bits suffice.
  localparam int CNT_W      = (MAX_SETTLE > 1) ? $clog2(MAX_SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       alu_a_q, alu_a_d;
  logic [N-1:0]       alu_b_q, alu_b_d;
  logic [5:0]         ctrl_q, ctrl_d;
  logic               pass_flags_q, pass_flags_d;
  logic [N-1:0]       result_q, result_d;
  logic [3:0]         flags_q, flags_d;   // {n, z, c, v}
  logic               err_q, err_d;

  // Opcode decode of the incoming request.
  logic [5:0] dec_code;
  logic       dec_legal;
  logic       dec_md;
  logic       dec_pass;

  // Combinational opcode decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    dec_code  = 6'b000000;
    dec_legal = 1'b1;
    dec_md    = 1'b0;
    dec_pass  = 1'b0;
    unique case (req_op)
      3'd0:    begin dec_code = 6'b000001; dec_pass = 1'b1; end
      3'd1:    begin dec_code = 6'b000010; dec_pass = 1'b1; end
      3'd2:    begin dec_code = 6'b000100; dec_md = 1'b1; dec_legal = (req_b != '0); end
      3'd3:    begin dec_code = 6'b000101; dec_md = 1'b1; end
      3'd4:    dec_code = 6'b000110;
      3'd5:    dec_code = 6'b000111;
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state and datapath update for the IDLE -> WAIT -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    ctrl_d       = ctrl_q;
    pass_flags_d = pass_flags_q;
    result_d     = result_q;
    flags_d      = flags_q;
    err_d        = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!dec_legal) begin
            // Rejected request: report an error without touching the ALU.
            result_d = '0;
            flags_d  = 4'b0000;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            alu_a_d      = req_a;
            alu_b_d      = req_b;
            ctrl_d       = dec_code;
            pass_flags_d = dec_pass;
            cnt_d        = dec_md ? CNT_W'(SETTLE_MD - 1) : CNT_W'(SETTLE - 1);
            state_d      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          result_d = alu_result;
          // Only add/sub update ALU flags; derive N/Z for the rest, C/V cleared.
          flags_d  = pass_flags_q ? {alu_n, alu_z, alu_c, alu_v}
                                  : {alu_result[N-1], (alu_result == '0), 2'b00};
          err_d    = 1'b0;
          ctrl_d   = 6'b000000;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      ctrl_q       <= 6'b000000;
      pass_flags_q <= 1'b0;
      result_q     <= '0;
      flags_q      <= 4'b0000;
      err_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      ctrl_q       <= ctrl_d;
      pass_flags_q <= pass_flags_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_result  = result_q;
  assign rsp_n       = flags_q[3];
  assign rsp_z       = flags_q[2];
  assign rsp_c       = flags_q[1];
  assign rsp_v       = flags_q[0];
  assign rsp_err     = err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = ctrl_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed vector table, randomized requests against a
// behavioural reference model, plus backpressure and reset-during-WAIT sequences.
module tb_alu_sequencer;

  localparam int N         = 32;
  localparam int SETTLE    = 1;
  localparam int SETTLE_MD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [2:0]   req_op;
  logic [N-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_n, rsp_z, rsp_c, rsp_v, rsp_err;
  logic [N-1:0] alu_a, alu_b;
  logic [5:0]   alu_control;
  logic [N-1:0] alu_result;
  logic         alu_n, alu_z, alu_c, alu_v;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N), .SETTLE(SETTLE), .SETTLE_MD(SETTLE_MD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v)
  );

  // Combinational ALU stand-in. Non add/sub ops drive junk flags (all ones) and an
  // idle control drives a junk result, so misuse of either shows up in the checks.
  always_comb begin
    logic [N:0] wide;
    wide       = '0;
    alu_result = 32'hBAD0_BAD0;
    {alu_n, alu_z, alu_c, alu_v} = 4'b1111;
    case (alu_control)
      6'b000001: begin
        wide       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = wide[N-1:0];
        alu_n      = alu_result[N-1];
        alu_z      = (alu_result == '0);
        alu_c      = wide[N];
        alu_v      = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
      end
      6'b000010: begin
        wide       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = wide[N-1:0];
        alu_n      = alu_result[N-1];
        alu_z      = (alu_result == '0);
        alu_c      = ~wide[N];
        alu_v      = (alu_a[N-1] != alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
      end
      6'b000100: alu_result = (alu_b != '0) ? alu_a / alu_b : '1;
      6'b000101: alu_result = alu_a * alu_b;
      6'b000110: alu_result = alu_a & alu_b;
      6'b000111: alu_result = alu_a | alu_b;
      default: ;
    endcase
  end

  typedef struct {
    logic [N-1:0] result;
    logic         n, z, c, v, err;
    int           lat;      // edges from acceptance to first rsp_valid
    logic [5:0]   ctrl;     // alu_control in the cycle after acceptance
    logic [5:0]   ctrl_or;  // OR of alu_control over the whole transaction
  } rsp_t;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a, b;
    rsp_t         exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic rsp_t mk(input logic [N-1:0] result, input logic [3:0] nzcv,
                              input logic err, input int lat, input logic [5:0] ctrl);
    rsp_t r;
    r.result = result;
    {r.n, r.z, r.c, r.v} = nzcv;
    r.err = err; r.lat = lat; r.ctrl = ctrl; r.ctrl_or = ctrl;
    return r;
  endfunction

  // Reference model: expected response computed from the opcode's meaning.
  function automatic rsp_t ref_model(input logic [2:0] op, input logic [N-1:0] a,
                                     input logic [N-1:0] b);
    rsp_t   r;
    longint sa, sb, s, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (N - 1);
    r = mk('0, 4'b0000, 1'b1, 1, 6'b000000);
    if (op > 3'd5 || (op == 3'd2 && b == '0)) return r;
    r.err = 1'b0;
    r.lat = (op == 3'd2 || op == 3'd3) ? SETTLE_MD + 1 : SETTLE + 1;
    case (op)
      3'd0: begin
        r.result = a + b; r.c = (a + b) < a;
        s = sa + sb; r.v = (s >= lim) || (s < -lim);
        r.ctrl = 6'd1;
      end
      3'd1: begin
        r.result = a - b; r.c = (a >= b);
        s = sa - sb; r.v = (s >= lim) || (s < -lim);
        r.ctrl = 6'd2;
      end
      3'd2: begin r.result = a / b; r.ctrl = 6'd4; end
      3'd3: begin r.result = a * b; r.ctrl = 6'd5; end
      3'd4: begin r.result = a & b; r.ctrl = 6'd6; end
      default: begin r.result = a | b; r.ctrl = 6'd7; end
    endcase
    r.n = r.result[N-1];
    r.z = (r.result == '0);
    r.ctrl_or = r.ctrl;
    return r;
  endfunction

  // Issue one request, wait (bounded) for the response, then consume it.
  task automatic run_txn(input string name, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, output rsp_t obs);
    @(negedge clk);
    check({name, "/req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
    obs.ctrl    = alu_control;
    obs.ctrl_or = 6'b000000;
    obs.lat     = 0;
    for (int k = 1; k <= 20; k++) begin
      obs.ctrl_or |= alu_control;
      if (rsp_valid) begin obs.lat = k; break; end
      @(posedge clk); #1;
    end
    obs.result = rsp_result;
    {obs.n, obs.z, obs.c, obs.v, obs.err} = {rsp_n, rsp_z, rsp_c, rsp_v, rsp_err};
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check({name, "/rsp_valid_drop"}, rsp_valid, 1'b0);
    check({name, "/req_ready_back"}, req_ready, 1'b1);
  endtask

  task automatic compare(input string name, input rsp_t obs, input rsp_t exp);
    check({name, "/result"},  obs.result,  exp.result);
    check({name, "/nzcv"},    {obs.n, obs.z, obs.c, obs.v}, {exp.n, exp.z, exp.c, exp.v});
    check({name, "/err"},     obs.err,     exp.err);
    check({name, "/latency"}, obs.lat,     exp.lat);
    check({name, "/ctrl"},    obs.ctrl,    exp.ctrl);
    check({name, "/ctrl_or"}, obs.ctrl_or, exp.ctrl_or);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    rsp_t obs;
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic         seen;

    vecs[0]  = '{3'd0, 32'd5,          32'd3,          mk(32'd8,          4'b0000, 0, 2, 6'b000001)};
    vecs[1]  = '{3'd1, 32'd3,          32'd5,          mk(32'hFFFF_FFFE,  4'b1000, 0, 2, 6'b000010)};
    vecs[2]  = '{3'd0, 32'h7FFF_FFFF,  32'd1,          mk(32'h8000_0000,  4'b1001, 0, 2, 6'b000001)};
    vecs[3]  = '{3'd3, 32'd6,          32'd7,          mk(32'd42,         4'b0000, 0, 5, 6'b000101)};
    vecs[4]  = '{3'd4, 32'hF0,         32'h0F,         mk(32'd0,          4'b0100, 0, 2, 6'b000110)};
    vecs[5]  = '{3'd6, 32'd11,         32'd22,         mk(32'd0,          4'b0000, 1, 1, 6'b000000)};
    vecs[6]  = '{3'd2, 32'd9,          32'd0,          mk(32'd0,          4'b0000, 1, 1, 6'b000000)};
    vecs[7]  = '{3'd5, 32'h8000_0000,  32'd1,          mk(32'h8000_0001,  4'b1000, 0, 2, 6'b000111)};
    vecs[8]  = '{3'd2, 32'd100,        32'd7,          mk(32'd14,         4'b0000, 0, 5, 6'b000100)};
    vecs[9]  = '{3'd0, 32'hFFFF_FFFF,  32'd1,          mk(32'd0,          4'b0110, 0, 2, 6'b000001)};
    vecs[10] = '{3'd7, 32'd1,          32'd1,          mk(32'd0,          4'b0000, 1, 1, 6'b000000)};
    vecs[11] = '{3'd1, 32'd5,          32'd5,          mk(32'd0,          4'b0110, 0, 2, 6'b000010)};

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/rsp_valid",   rsp_valid, 1'b0);
    check("reset/rsp_fields",  {rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err}, '0);
    check("reset/alu_ops",     {alu_a, alu_b}, '0);
    check("reset/alu_control", alu_control, 6'b000000);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset/req_ready", req_ready, 1'b1);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, obs);
      compare($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      run_txn($sformatf("rnd%0d", i), op, a, b, obs);
      compare($sformatf("rnd%0d", i), obs, ref_model(op, a, b));
    end

    // Backpressure: response held for 10 cycles while a competing request is offered.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd10; req_b = 32'd20;
    @(posedge clk); #1;
    req_op = 3'd1; req_a = 32'd99; req_b = 32'd1;   // offered but must be ignored
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      seen = rsp_valid;
      if (!seen) begin @(posedge clk); #1; end
    end
    check("bp/rsp_valid_seen", seen, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp/hold%0d_valid", k), rsp_valid, 1'b1);
      check($sformatf("bp/hold%0d_rsp", k), {rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err},
            {32'd30, 5'b00000});
      check($sformatf("bp/hold%0d_req_ready", k), req_ready, 1'b0);
    end
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check("bp/req_ready_after", req_ready, 1'b1);
    check("bp/rsp_valid_after", rsp_valid, 1'b0);
    check("bp/result_held",     rsp_result, 32'd30);

    // Reset during WAIT of a divide: outputs clear at once, no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_a = 32'd100; req_b = 32'd5;
    @(posedge clk); #1; req_valid = 1'b0;
    check("rstwait/ctrl_div", alu_control, 6'b000100);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstwait/alu_control", alu_control, 6'b000000);
    check("rstwait/alu_ops",     {alu_a, alu_b}, '0);
    check("rstwait/rsp_valid",   rsp_valid, 1'b0);
    check("rstwait/rsp_fields",  {rsp_result, rsp_err}, '0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen |= rsp_valid;
    end
    check("rstwait/no_rsp_pulse", seen, 1'b0);
    run_txn("rstwait/next", 3'd2, 32'd100, 32'd5, obs);
    compare("rstwait/next", obs, mk(32'd20, 4'b0000, 0, SETTLE_MD + 1, 6'b000100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
